// File: rtl/udt_cfg_axil_slave.sv
// AXI4-Lite configuration/connection-control register file for the UDT engine.
// Optional UDT_CFG_IRQ_EN adds an irq output and a write-only IRQ_CLR register at index 8.
module udt_cfg_axil_slave #(
  parameter int ADDR_W       = 8,
  parameter int MSS_MAX      = 1500,
  parameter int BUF_MAX      = 8192,
  parameter int FLIGHT_MAX   = 256000,
  parameter int PEER_RES_CYC = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ctrl_s_axi_awvalid,
  output logic              ctrl_s_axi_awready,
  input  logic [ADDR_W-1:0] ctrl_s_axi_awaddr,
  input  logic              ctrl_s_axi_wvalid,
  output logic              ctrl_s_axi_wready,
  input  logic [31:0]       ctrl_s_axi_wdata,
  input  logic [3:0]        ctrl_s_axi_wstrb,
  output logic              ctrl_s_axi_bvalid,
  input  logic              ctrl_s_axi_bready,
  output logic [1:0]        ctrl_s_axi_bresp,
  input  logic              ctrl_s_axi_arvalid,
  output logic              ctrl_s_axi_arready,
  input  logic [ADDR_W-1:0] ctrl_s_axi_araddr,
  output logic              ctrl_s_axi_rvalid,
  input  logic              ctrl_s_axi_rready,
  output logic [31:0]       ctrl_s_axi_rdata,
  output logic [1:0]        ctrl_s_axi_rresp,
  output logic              Req_Connect,
  input  logic              Res_Connect,
  output logic              Req_Close,
  input  logic              Res_Close,
  input  logic [31:0]       udt_state,
  input  logic              state_valid,
  output logic              state_ready,
  input  logic              Peer_Req_Close,
  output logic              Peer_Res_Close,
  output logic              user_valid,
  input  logic              user_ready,
  output logic [31:0]       mmsize,
  output logic [31:0]       snd_buf,
  output logic [31:0]       rev_buf,
  output logic [31:0]       flight_sz,
  output logic [31:0]       init_seq
`ifdef UDT_CFG_IRQ_EN
  ,
  output logic              irq
`endif
);

`ifdef UDT_CFG_IRQ_EN
  localparam int MAX_IDX = 8;
`else
  localparam int MAX_IDX = 7;
`endif
  localparam int CNT_W = $clog2(PEER_RES_CYC) + 1;

  typedef enum logic [1:0] {W_ADDR, W_DATA, W_RESP} wstate_t;
  typedef enum logic {R_ADDR, R_DATA} rstate_t;
  typedef enum logic [2:0] {CLOSED, CONNECTING, WAIT_EST, ESTAB, CLOSING, WAIT_CLS,
                            PEER_NOTIFY, PEER_DONE} conn_t;

  wstate_t             wstate;
  rstate_t             rstate;
  conn_t               conn;
  logic [ADDR_W-1:0]   waddr;
  logic [3:0]          cfg_err;
  logic [31:0]         status;
  logic [CNT_W-1:0]    peer_cnt;

  logic [3:0]  wsel, rsel;
  logic        bad_w, bad_r, w_fire, st_fire, over;
  logic [31:0] cur, merged, rdata_nxt;
  logic [1:0]  wresp_nxt, rresp_nxt;
  logic        cfg_we, err_set, connect_cmd, close_cmd, irq_clr;

  assign wsel    = waddr[3:0];
  assign rsel    = ctrl_s_axi_araddr[3:0];
  assign bad_w   = waddr > ADDR_W'(MAX_IDX);
  assign bad_r   = ctrl_s_axi_araddr > ADDR_W'(MAX_IDX);
  assign w_fire  = (wstate == W_DATA) && ctrl_s_axi_wvalid;
  assign st_fire = state_valid && state_ready;

  // Decode the pending write: merge strobes, range-check, and decide the response.
  always_comb begin
    cur = '0;
    case (wsel)
      4'd0: cur = mmsize;
      4'd1: cur = snd_buf;
      4'd2: cur = rev_buf;
      4'd3: cur = flight_sz;
      4'd4: cur = init_seq;
      default: cur = '0;
    endcase
    merged = cur;
    for (int b = 0; b < 4; b++)
      if (ctrl_s_axi_wstrb[b]) merged[8*b +: 8] = ctrl_s_axi_wdata[8*b +: 8];
    over = 1'b0;
    case (wsel)
      4'd0:       over = merged > 32'(MSS_MAX);
      4'd1, 4'd2: over = merged > 32'(BUF_MAX);
      4'd3:       over = merged > 32'(FLIGHT_MAX);
      default:    over = 1'b0;
    endcase
    wresp_nxt   = 2'b00;
    cfg_we      = 1'b0;
    err_set     = 1'b0;
    connect_cmd = 1'b0;
    close_cmd   = 1'b0;
    irq_clr     = 1'b0;
    if (bad_w) wresp_nxt = 2'b01;
    else if (wsel <= 4'd4) begin
      if (conn != CLOSED) wresp_nxt = 2'b10;
      else if (over) begin
        wresp_nxt = 2'b11;
        err_set   = 1'b1;
      end else cfg_we = 1'b1;
    end else if (wsel == 4'd5) begin
      if (conn == CLOSED) connect_cmd = 1'b1;
      else wresp_nxt = 2'b10;
    end else if (wsel == 4'd6) begin
      // A peer close arriving in the same cycle takes priority over a local close.
      if (conn == ESTAB && !Peer_Req_Close) close_cmd = 1'b1;
      else wresp_nxt = 2'b10;
    end
`ifdef UDT_CFG_IRQ_EN
    else if (wsel == 4'd8) irq_clr = 1'b1;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wstate <= W_ADDR;
      ctrl_s_axi_awready <= 1'b1;
      ctrl_s_axi_wready  <= 1'b0;
      ctrl_s_axi_bvalid  <= 1'b0;
      ctrl_s_axi_bresp   <= 2'b00;
      waddr     <= '0;
      cfg_err   <= '0;
      mmsize    <= '0;
      snd_buf   <= '0;
      rev_buf   <= '0;
      flight_sz <= '0;
      init_seq  <= '0;
    end else begin
      case (wstate)
        W_ADDR: if (ctrl_s_axi_awvalid) begin
          waddr <= ctrl_s_axi_awaddr;
          ctrl_s_axi_awready <= 1'b0;
          ctrl_s_axi_wready  <= 1'b1;
          wstate <= W_DATA;
        end
        W_DATA: if (ctrl_s_axi_wvalid) begin
          ctrl_s_axi_wready <= 1'b0;
          ctrl_s_axi_bvalid <= 1'b1;
          ctrl_s_axi_bresp  <= wresp_nxt;
          wstate <= W_RESP;
          if (cfg_we) begin
            case (wsel)
              4'd0: mmsize    <= merged;
              4'd1: snd_buf   <= merged;
              4'd2: rev_buf   <= merged;
              4'd3: flight_sz <= merged;
              4'd4: init_seq  <= merged;
              default: ;
            endcase
            if (wsel < 4'd4) cfg_err[wsel[1:0]] <= 1'b0;
          end
          if (err_set) cfg_err[wsel[1:0]] <= 1'b1;
        end
        default: if (ctrl_s_axi_bready) begin
          ctrl_s_axi_bvalid  <= 1'b0;
          ctrl_s_axi_awready <= 1'b1;
          wstate <= W_ADDR;
        end
      endcase
    end
  end

  always_comb begin
    rdata_nxt = '0;
    rresp_nxt = 2'b00;
    if (bad_r) begin
      rdata_nxt = 32'hFFFF_FFFF;
      rresp_nxt = 2'b01;
    end else if (rsel < 4'd4 && cfg_err[rsel[1:0]]) begin
      rdata_nxt = 32'hFFFF_FFFF;
      rresp_nxt = 2'b11;
    end else begin
      case (rsel)
        4'd0: rdata_nxt = mmsize;
        4'd1: rdata_nxt = snd_buf;
        4'd2: rdata_nxt = rev_buf;
        4'd3: rdata_nxt = flight_sz;
        4'd4: rdata_nxt = init_seq;
        4'd7: rdata_nxt = status;
        default: rdata_nxt = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rstate <= R_ADDR;
      ctrl_s_axi_arready <= 1'b1;
      ctrl_s_axi_rvalid  <= 1'b0;
      ctrl_s_axi_rdata   <= '0;
      ctrl_s_axi_rresp   <= 2'b00;
    end else begin
      case (rstate)
        R_ADDR: if (ctrl_s_axi_arvalid) begin
          ctrl_s_axi_arready <= 1'b0;
          ctrl_s_axi_rvalid  <= 1'b1;
          ctrl_s_axi_rdata   <= rdata_nxt;
          ctrl_s_axi_rresp   <= rresp_nxt;
          rstate <= R_DATA;
        end
        default: if (ctrl_s_axi_rready) begin
          ctrl_s_axi_rvalid  <= 1'b0;
          ctrl_s_axi_arready <= 1'b1;
          rstate <= R_ADDR;
        end
      endcase
    end
  end

  // Connection lifecycle; engine state reports always refresh STATUS.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conn           <= CLOSED;
      Req_Connect    <= 1'b0;
      Req_Close      <= 1'b0;
      user_valid     <= 1'b0;
      Peer_Res_Close <= 1'b0;
      peer_cnt       <= '0;
      status         <= '0;
      state_ready    <= 1'b0;
    end else begin
      state_ready <= 1'b1;
      if (st_fire) status <= udt_state;
      case (conn)
        CLOSED: if (w_fire && connect_cmd) begin
          conn <= CONNECTING;
          Req_Connect <= 1'b1;
        end
        CONNECTING: if (Res_Connect) begin
          conn <= WAIT_EST;
          Req_Connect <= 1'b0;
        end
        WAIT_EST: if (st_fire && udt_state[4]) conn <= ESTAB;
        ESTAB: begin
          if (Peer_Req_Close) begin
            conn <= PEER_NOTIFY;
            user_valid <= 1'b1;
          end else if (w_fire && close_cmd) begin
            conn <= CLOSING;
            Req_Close <= 1'b1;
          end
        end
        CLOSING: if (Res_Close) begin
          conn <= WAIT_CLS;
          Req_Close <= 1'b0;
        end
        WAIT_CLS: if (st_fire && udt_state[12]) conn <= CLOSED;
        PEER_NOTIFY: if (user_ready) begin
          conn <= PEER_DONE;
          user_valid <= 1'b0;
          Peer_Res_Close <= 1'b1;
          peer_cnt <= '0;
        end
        default: begin
          if (peer_cnt == CNT_W'(PEER_RES_CYC - 1)) begin
            Peer_Res_Close <= 1'b0;
            conn <= CLOSED;
          end else peer_cnt <= peer_cnt + 1'b1;
        end
      endcase
    end
  end

`ifdef UDT_CFG_IRQ_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) irq <= 1'b0;
    else if (st_fire || (conn == ESTAB && Peer_Req_Close)) irq <= 1'b1;
    else if (w_fire && irq_clr) irq <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_udt_cfg_axil_slave.sv
// Self-checking bench for udt_cfg_axil_slave: directed connection flows plus randomized
// config traffic checked against a register/connection reference model.
module tb_udt_cfg_axil_slave;
  localparam int ADDR_W     = 8;
  localparam int MSS_MAX    = 1500;
  localparam int BUF_MAX    = 8192;
  localparam int FLIGHT_MAX = 256000;
`ifdef UDT_CFG_IRQ_EN
  localparam int MAX_IDX = 8;
`else
  localparam int MAX_IDX = 7;
`endif

  logic clk = 1'b0, rst_n = 1'b0;
  logic awvalid = 0, awready, wvalid = 0, wready, bvalid, bready = 0;
  logic arvalid = 0, arready, rvalid, rready = 0;
  logic [ADDR_W-1:0] awaddr = '0, araddr = '0;
  logic [31:0] wdata = '0, rdata;
  logic [3:0]  wstrb = '0;
  logic [1:0]  bresp, rresp;
  logic Req_Connect, Res_Connect = 0, Req_Close, Res_Close = 0;
  logic [31:0] udt_state = '0;
  logic state_valid = 0, state_ready;
  logic Peer_Req_Close = 0, Peer_Res_Close, user_valid, user_ready = 0;
  logic [31:0] mmsize, snd_buf, rev_buf, flight_sz, init_seq;
`ifdef UDT_CFG_IRQ_EN
  logic irq;
`endif

  udt_cfg_axil_slave #(.ADDR_W(ADDR_W), .MSS_MAX(MSS_MAX), .BUF_MAX(BUF_MAX),
                       .FLIGHT_MAX(FLIGHT_MAX), .PEER_RES_CYC(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .ctrl_s_axi_awvalid(awvalid), .ctrl_s_axi_awready(awready), .ctrl_s_axi_awaddr(awaddr),
    .ctrl_s_axi_wvalid(wvalid), .ctrl_s_axi_wready(wready), .ctrl_s_axi_wdata(wdata),
    .ctrl_s_axi_wstrb(wstrb), .ctrl_s_axi_bvalid(bvalid), .ctrl_s_axi_bready(bready),
    .ctrl_s_axi_bresp(bresp), .ctrl_s_axi_arvalid(arvalid), .ctrl_s_axi_arready(arready),
    .ctrl_s_axi_araddr(araddr), .ctrl_s_axi_rvalid(rvalid), .ctrl_s_axi_rready(rready),
    .ctrl_s_axi_rdata(rdata), .ctrl_s_axi_rresp(rresp),
    .Req_Connect(Req_Connect), .Res_Connect(Res_Connect), .Req_Close(Req_Close),
    .Res_Close(Res_Close), .udt_state(udt_state), .state_valid(state_valid),
    .state_ready(state_ready), .Peer_Req_Close(Peer_Req_Close),
    .Peer_Res_Close(Peer_Res_Close), .user_valid(user_valid), .user_ready(user_ready),
    .mmsize(mmsize), .snd_buf(snd_buf), .rev_buf(rev_buf), .flight_sz(flight_sz),
    .init_seq(init_seq)
`ifdef UDT_CFG_IRQ_EN
    , .irq(irq)
`endif
  );

  always #5 clk = ~clk;

  int compared = 0, mismatched = 0;
  logic [31:0] mdl_cfg [5];
  bit          mdl_err [4];
  bit          mdl_closed, mdl_estab;
  logic [31:0] mdl_status;
  logic        snap_conn, snap_close;

  function automatic logic [31:0] limitOf(input int idx);
    case (idx)
      0: return 32'(MSS_MAX);
      1, 2: return 32'(BUF_MAX);
      3: return 32'(FLIGHT_MAX);
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  function automatic logic [31:0] cfgPort(input int idx);
    case (idx)
      0: return mmsize;
      1: return snd_buf;
      2: return rev_buf;
      3: return flight_sz;
      default: return init_seq;
    endcase
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 5; i++) mdl_cfg[i] = '0;
    for (int i = 0; i < 4; i++) mdl_err[i] = 1'b0;
    mdl_closed = 1'b1;
    mdl_estab  = 1'b0;
    mdl_status = '0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic timeoutFail(input string tag);
    compared++;
    mismatched++;
    $display("[TB] FAIL timeout %s", tag);
  endtask

  task automatic axiWrite(input int idx, input logic [31:0] data, input logic [3:0] strb,
                          input bit peer, output logic [1:0] resp);
    int n;
    awvalid = 1'b1;
    awaddr  = ADDR_W'(idx);
    n = 0;
    while (!awready && n < 50) begin @(posedge clk); #1; n++; end
    if (!awready) timeoutFail("awready");
    @(posedge clk); #1;
    awvalid = 1'b0;
    wvalid = 1'b1;
    wdata  = data;
    wstrb  = strb;
    if (peer) Peer_Req_Close = 1'b1;
    n = 0;
    while (!wready && n < 50) begin @(posedge clk); #1; n++; end
    if (!wready) timeoutFail("wready");
    @(posedge clk); #1;
    wvalid = 1'b0;
    Peer_Req_Close = 1'b0;
    snap_conn  = Req_Connect;
    snap_close = Req_Close;
    bready = 1'b1;
    n = 0;
    while (!bvalid && n < 50) begin @(posedge clk); #1; n++; end
    if (!bvalid) timeoutFail("bvalid");
    resp = bresp;
    @(posedge clk); #1;
    bready = 1'b0;
  endtask

  task automatic axiRead(input int idx, output logic [31:0] data, output logic [1:0] resp);
    int n;
    arvalid = 1'b1;
    araddr  = ADDR_W'(idx);
    n = 0;
    while (!arready && n < 50) begin @(posedge clk); #1; n++; end
    if (!arready) timeoutFail("arready");
    @(posedge clk); #1;
    arvalid = 1'b0;
    rready = 1'b1;
    n = 0;
    while (!rvalid && n < 50) begin @(posedge clk); #1; n++; end
    if (!rvalid) timeoutFail("rvalid");
    data = rdata;
    resp = rresp;
    @(posedge clk); #1;
    rready = 1'b0;
  endtask

  // Predict the write response from the register rules, update the model, then compare.
  task automatic applyStimulus(input string tag, input int idx, input logic [31:0] data,
                               input logic [3:0] strb, input bit peer);
    logic [1:0]  exp, got;
    logic [31:0] m;
    exp = 2'b00;
    if (idx > MAX_IDX) exp = 2'b01;
    else if (idx <= 4) begin
      m = mdl_cfg[idx];
      for (int b = 0; b < 4; b++) if (strb[b]) m[8*b +: 8] = data[8*b +: 8];
      if (!mdl_closed) exp = 2'b10;
      else if (idx < 4 && m > limitOf(idx)) begin
        exp = 2'b11;
        mdl_err[idx] = 1'b1;
      end else begin
        mdl_cfg[idx] = m;
        if (idx < 4) mdl_err[idx] = 1'b0;
      end
    end else if (idx == 5) begin
      if (mdl_closed) mdl_closed = 1'b0;
      else exp = 2'b10;
    end else if (idx == 6) begin
      if (mdl_estab && !peer) mdl_estab = 1'b0;
      else exp = 2'b10;
    end
    if (peer && mdl_estab) mdl_estab = 1'b0;
    axiWrite(idx, data, strb, peer, got);
    checkOutput($sformatf("%s_bresp", tag), 32'(got), 32'(exp));
  endtask

  task automatic readCheck(input string tag, input int idx);
    logic [31:0] expd, gotd;
    logic [1:0]  expr, gotr;
    expr = 2'b00;
    if (idx > MAX_IDX) begin expd = 32'hFFFF_FFFF; expr = 2'b01; end
    else if (idx < 4 && mdl_err[idx]) begin expd = 32'hFFFF_FFFF; expr = 2'b11; end
    else if (idx <= 4) expd = mdl_cfg[idx];
    else if (idx == 7) expd = mdl_status;
    else expd = '0;
    axiRead(idx, gotd, gotr);
    checkOutput($sformatf("%s_rdata", tag), gotd, expd);
    checkOutput($sformatf("%s_rresp", tag), 32'(gotr), 32'(expr));
  endtask

  task automatic sendState(input logic [31:0] val);
    int n;
    state_valid = 1'b1;
    udt_state = val;
    n = 0;
    while (!state_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (!state_ready) timeoutFail("state_ready");
    @(posedge clk); #1;
    state_valid = 1'b0;
    mdl_status = val;
  endtask

  task automatic connectAndClose(input int pass);
    applyStimulus($sformatf("conn%0d_w5", pass), 5, $urandom, 4'hF, 1'b0);
    checkOutput($sformatf("conn%0d_req_conn_next", pass), 32'(snap_conn), 32'd1);
    Res_Connect = 1'b1; @(posedge clk); #1; Res_Connect = 1'b0;
    checkOutput($sformatf("conn%0d_req_conn_drop", pass), 32'(Req_Connect), 32'd0);
    sendState(32'h10);
    mdl_estab = 1'b1;
    readCheck($sformatf("conn%0d_status", pass), 7);
    applyStimulus($sformatf("conn%0d_w6", pass), 6, $urandom, 4'hF, 1'b0);
    checkOutput($sformatf("conn%0d_req_close", pass), 32'(snap_close), 32'd1);
    Res_Close = 1'b1; @(posedge clk); #1; Res_Close = 1'b0;
    checkOutput($sformatf("conn%0d_req_close_drop", pass), 32'(Req_Close), 32'd0);
    sendState(32'h1000);
    mdl_closed = 1'b1;
    applyStimulus($sformatf("conn%0d_closed_cfg", pass), 4, 32'(pass + 77), 4'hF, 1'b0);
  endtask

  initial begin
    int idx, cnt;
    logic [31:0] v;
    modelReset();
    #12;
    checkOutput("rst_awready", 32'(awready), 32'd1);
    checkOutput("rst_arready", 32'(arready), 32'd1);
    checkOutput("rst_wready", 32'(wready), 32'd0);
    checkOutput("rst_bvalid", 32'(bvalid), 32'd0);
    checkOutput("rst_rvalid", 32'(rvalid), 32'd0);
    checkOutput("rst_state_ready", 32'(state_ready), 32'd0);
    checkOutput("rst_req", {28'd0, Req_Connect, Req_Close, user_valid, Peer_Res_Close}, 32'd0);
    checkOutput("rst_mmsize", mmsize, 32'd0);
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("state_ready_up", 32'(state_ready), 32'd1);

    wvalid = 1'b1; wdata = 32'd55; wstrb = 4'hF;
    repeat (2) @(posedge clk); #1;
    checkOutput("w_before_aw", 32'(wready), 32'd0);
    wvalid = 1'b0;

    applyStimulus("init0", 0, 32'd0, 4'hF, 1'b0);
    applyStimulus("init1", 1, 32'd1024, 4'hF, 1'b0);
    applyStimulus("init2", 2, 32'd1024, 4'hF, 1'b0);
    applyStimulus("init3", 3, 32'd10240, 4'hF, 1'b0);
    applyStimulus("init4", 4, 32'd10101, 4'hF, 1'b0);
    for (int i = 0; i < 5; i++) readCheck($sformatf("init_rd%0d", i), i);
    checkOutput("port_flight", flight_sz, 32'd10240);

    applyStimulus("strb", 1, 32'h0000_0300, 4'b0010, 1'b0);
    checkOutput("port_snd_strb", snd_buf, mdl_cfg[1]);

    applyStimulus("oor0", 0, 32'd8100, 4'hF, 1'b0);
    readCheck("oor0", 0);
    applyStimulus("oor1", 1, 32'd8193, 4'hF, 1'b0);
    readCheck("oor1", 1);
    applyStimulus("oor2", 2, 32'd8193, 4'hF, 1'b0);
    readCheck("oor2", 2);
    applyStimulus("oor3", 3, 32'd256001, 4'hF, 1'b0);
    readCheck("oor3", 3);
    applyStimulus("edge0", 0, 32'd1500, 4'hF, 1'b0);
    readCheck("edge0", 0);
    applyStimulus("edge3", 3, 32'd256000, 4'hF, 1'b0);
    readCheck("edge3", 3);

    applyStimulus("bad10", 'h10, 32'd1, 4'hF, 1'b0);
    readCheck("bad10", 'h10);
    applyStimulus("bad8", 8, 32'd1, 4'hF, 1'b0);
    for (int i = 0; i < 5; i++) readCheck($sformatf("bad_keep%0d", i), i);

    for (int i = 0; i < 24; i++) begin
      idx = $urandom_range(0, 4);
      if (idx == 4) v = $urandom;
      else if ($urandom_range(0, 3) == 0) v = limitOf(idx) + 32'($urandom_range(1, 1000));
      else v = 32'($urandom_range(0, int'(limitOf(idx))));
      applyStimulus($sformatf("rnd%0d", i), idx, v, 4'hF, 1'b0);
      readCheck($sformatf("rnd%0d", i), idx);
      if (idx == 4 || !mdl_err[idx])
        checkOutput($sformatf("rnd%0d_port", i), cfgPort(idx), mdl_cfg[idx]);
      if (i % 6 == 0) begin
        idx = $urandom_range(MAX_IDX + 1, 255);
        applyStimulus($sformatf("rndbad%0d", i), idx, $urandom, 4'hF, 1'b0);
        readCheck($sformatf("rndbad%0d", i), idx);
      end
    end

    applyStimulus("close_in_closed", 6, 32'd0, 4'hF, 1'b0);
    checkOutput("close_in_closed_req", 32'(Req_Close), 32'd0);
    connectAndClose(0);
    connectAndClose(1);

    applyStimulus("pc_w5", 5, 32'd0, 4'hF, 1'b0);
    Res_Connect = 1'b1; @(posedge clk); #1; Res_Connect = 1'b0;
    sendState(32'h0000_0011);
    mdl_estab = 1'b1;
    applyStimulus("estab_cfg", 1, 32'd512, 4'hF, 1'b0);
    checkOutput("estab_cfg_port", snd_buf, mdl_cfg[1]);
    applyStimulus("estab_w5", 5, 32'd0, 4'hF, 1'b0);
    checkOutput("estab_w5_req", 32'(Req_Connect), 32'd0);
    readCheck("estab_status", 7);
    Peer_Req_Close = 1'b1;
    @(posedge clk); #1;
    Peer_Req_Close = 1'b0;
    mdl_estab = 1'b0;
    checkOutput("peer_user_valid", 32'(user_valid), 32'd1);
    user_ready = 1'b1; @(posedge clk); #1; user_ready = 1'b0;
    checkOutput("peer_user_valid_drop", 32'(user_valid), 32'd0);
    cnt = 0;
    while (Peer_Res_Close && cnt < 10) begin cnt++; @(posedge clk); #1; end
    checkOutput("peer_res_len", 32'(cnt), 32'd2);
    mdl_closed = 1'b1;
    applyStimulus("peer_closed_cfg", 2, 32'd4096, 4'hF, 1'b0);

    applyStimulus("sim_w5", 5, 32'd0, 4'hF, 1'b0);
    Res_Connect = 1'b1; @(posedge clk); #1; Res_Connect = 1'b0;
    sendState(32'h10);
    mdl_estab = 1'b1;
    applyStimulus("sim_w6_peer", 6, 32'd0, 4'hF, 1'b1);
    checkOutput("sim_req_close", 32'(Req_Close), 32'd0);
    checkOutput("sim_user_valid", 32'(user_valid), 32'd1);
    user_ready = 1'b1; @(posedge clk); #1; user_ready = 1'b0;
    repeat (3) @(posedge clk); #1;
    mdl_closed = 1'b1;
    applyStimulus("sim_closed_cfg", 0, 32'd1000, 4'hF, 1'b0);

    applyStimulus("mid_w5", 5, 32'd0, 4'hF, 1'b0);
    awvalid = 1'b1; awaddr = ADDR_W'(1);
    @(posedge clk); #1;
    awvalid = 1'b0;
    rst_n = 1'b0; #1;
    checkOutput("mid_rst_wready", 32'(wready), 32'd0);
    checkOutput("mid_rst_awready", 32'(awready), 32'd1);
    checkOutput("mid_rst_req_conn", 32'(Req_Connect), 32'd0);
    checkOutput("mid_rst_mmsize", mmsize, 32'd0);
    modelReset();
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;
    applyStimulus("post_rst_cfg", 0, 32'd700, 4'hF, 1'b0);
    readCheck("post_rst_rd", 0);
    readCheck("post_rst_status", 7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end
endmodule
